// File: rtl/rom_ctrl_mux_multi.sv
// rom_ctrl_mux_multi: monotonic N-channel mux in front of the ROM with a
// response-tracking FIFO that returns each read response to the channel that
// issued it, plus a sticky fatal alert for select/ownership/tracking faults.
module rom_ctrl_mux_multi #(
  parameter int unsigned NumCh = 3,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 39,
  parameter int unsigned Depth = 2,
  localparam int unsigned IdxW = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*NumCh-1:0]    sel_i,
  input  logic [NumCh-1:0]      req_i,
  input  logic [AW*NumCh-1:0]   addr_i,
  output logic [NumCh-1:0]      gnt_o,
  output logic [NumCh-1:0]      rvalid_o,
  output logic [DW-1:0]         rdata_o,
  output logic [IdxW-1:0]       owner_o,
  output logic                  rom_req_o,
  output logic [AW-1:0]         rom_addr_o,
  input  logic [DW-1:0]         rom_rdata_i,
  input  logic                  rom_rvalid_i,
  output logic                  alert_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [3:0]  MuBi4True  = 4'h6;
  localparam logic [3:0]  MuBi4False = 4'h9;

  logic [IdxW-1:0] owner_q, owner_qq, eff_owner, hi_in, head;
  logic [IdxW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q, wptr_nxt, rptr_nxt;
  logic [CntW-1:0] cnt_q;
  logic            init_q, alert_q, alert_d;
  logic            sel_bad, owner_sel_true, reverted;
  logic            fifo_empty, fifo_full, gnt_ok, req_sel, push, pop, wr_en;

  // Decode selects: highest strictly-true channel, invalid encodings, owner still true
  always_comb begin
    hi_in          = '0;
    sel_bad        = 1'b0;
    owner_sel_true = 1'b0;
    for (int unsigned c = 1; c < NumCh; c++) begin
      if (sel_i[4*c +: 4] == MuBi4True) hi_in = IdxW'(c);
      if (sel_i[4*c +: 4] != MuBi4True && sel_i[4*c +: 4] != MuBi4False) sel_bad = 1'b1;
      if (IdxW'(c) == owner_q && sel_i[4*c +: 4] == MuBi4True) owner_sel_true = 1'b1;
    end
  end

  assign eff_owner  = (hi_in > owner_q) ? hi_in : owner_q;
  assign reverted   = (owner_q != '0) && !owner_sel_true;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntW'(Depth));
  // Grants stay low until the first clock after reset so reset outputs are quiet
  assign gnt_ok     = init_q && (!fifo_full || rom_rvalid_i);
  assign head       = mem_q[rptr_q];
  assign pop        = rom_rvalid_i && !fifo_empty;
  assign push       = rom_req_o;
  assign wr_en      = push && (!fifo_full || pop);
  assign wptr_nxt   = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
  assign rptr_nxt   = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);

  // Route grant, request and address for the effective owner only
  always_comb begin
    gnt_o      = '0;
    req_sel    = 1'b0;
    rom_addr_o = '0;
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (IdxW'(c) == eff_owner) begin
        gnt_o[c]   = gnt_ok;
        req_sel    = req_i[c];
        rom_addr_o = addr_i[AW*c +: AW];
      end
    end
  end

  assign rom_req_o = req_sel && gnt_ok;

  // Steer the ROM response to the channel recorded at the FIFO head
  always_comb begin
    rvalid_o = '0;
    for (int unsigned c = 0; c < NumCh; c++) begin
      rvalid_o[c] = pop && (head == IdxW'(c));
    end
  end

  assign rdata_o = rom_rdata_i;

  // Fatal conditions: bad select, reverted select, owner regression, underflow, overflow
  assign alert_d = sel_bad || reverted || (owner_qq > owner_q) ||
                   (rom_rvalid_i && fifo_empty) || (push && fifo_full && !rom_rvalid_i);

  // Ownership, tracking FIFO and sticky alert state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_q   <= 1'b0;
      owner_q  <= '0;
      owner_qq <= '0;
      alert_q  <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      init_q   <= 1'b1;
      owner_q  <= eff_owner;
      owner_qq <= owner_q;
      alert_q  <= alert_q | alert_d;
      if (wr_en) begin
        mem_q[wptr_q] <= eff_owner;
        wptr_q        <= wptr_nxt;
      end
      if (pop) rptr_q <= rptr_nxt;
      if (wr_en && !pop)      cnt_q <= cnt_q + CntW'(1);
      else if (pop && !wr_en) cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign owner_o = owner_q;
  assign alert_o = alert_q;

endmodule

// File: tb/tb_rom_ctrl_mux_multi.sv
// Directed bench for rom_ctrl_mux_multi (NumCh=3, AW=8, DW=39, Depth=2).
module tb_rom_ctrl_mux_multi;

  localparam int unsigned NumCh = 3;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 39;
  localparam int unsigned Depth = 2;
  localparam int unsigned IdxW  = 2;
  localparam logic [3:0]  T4 = 4'h6;
  localparam logic [3:0]  F4 = 4'h9;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [4*NumCh-1:0]  sel_i;
  logic [NumCh-1:0]    req_i;
  logic [AW*NumCh-1:0] addr_i;
  logic [NumCh-1:0]    gnt_o;
  logic [NumCh-1:0]    rvalid_o;
  logic [DW-1:0]       rdata_o;
  logic [IdxW-1:0]     owner_o;
  logic                rom_req_o;
  logic [AW-1:0]       rom_addr_o;
  logic [DW-1:0]       rom_rdata_i;
  logic                rom_rvalid_i;
  logic                alert_o;

  int n_cmp = 0;
  int n_bad = 0;

  rom_ctrl_mux_multi #(.NumCh(NumCh), .AW(AW), .DW(DW), .Depth(Depth)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .req_i(req_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .owner_o(owner_o),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i),
    .rom_rvalid_i(rom_rvalid_i), .alert_o(alert_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_sel(input int c, input logic [3:0] v);
    sel_i[4*c +: 4] = v;
  endtask

  task automatic set_addr(input int c, input logic [AW-1:0] v);
    addr_i[AW*c +: AW] = v;
  endtask

  task automatic idle_inputs();
    sel_i = {F4, F4, F4};
    req_i = '0;
    addr_i = '0;
    rom_rdata_i = '0;
    rom_rvalid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    n_cmp++; if (gnt_o !== 3'b000) begin n_bad++; $display("FAIL reset_gnt: got %b want %b", gnt_o, 3'b000); end
    n_cmp++; if (rvalid_o !== 3'b000) begin n_bad++; $display("FAIL reset_rvalid: got %b want %b", rvalid_o, 3'b000); end
    n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_rom_req: got %b want 0", rom_req_o); end
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", owner_o); end
    n_cmp++; if (alert_o !== 1'b0) begin n_bad++; $display("FAIL reset_alert: got %b want 0", alert_o); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic_read();
    req_i = 3'b001;
    set_addr(0, 8'h10);
    #1;
    n_cmp++; if (gnt_o !== 3'b001) begin n_bad++; $display("FAIL basic_gnt: got %b want %b", gnt_o, 3'b001); end
    n_cmp++; if (rom_req_o !== 1'b1) begin n_bad++; $display("FAIL basic_rom_req: got %b want 1", rom_req_o); end
    n_cmp++; if (rom_addr_o !== 8'h10) begin n_bad++; $display("FAIL basic_rom_addr: got %h want 10", rom_addr_o); end
    step();
    req_i = 3'b000;
    rom_rvalid_i = 1'b1;
    rom_rdata_i = 39'h1234;
    #1;
    n_cmp++; if (rvalid_o !== 3'b001) begin n_bad++; $display("FAIL basic_rvalid: got %b want %b", rvalid_o, 3'b001); end
    n_cmp++; if (rdata_o !== 39'h1234) begin n_bad++; $display("FAIL basic_rdata: got %h want 1234", rdata_o); end
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL basic_owner: got %0d want 0", owner_o); end
    n_cmp++; if (alert_o !== 1'b0) begin n_bad++; $display("FAIL basic_alert: got %b want 0", alert_o); end
    step();
    rom_rvalid_i = 1'b0;
  endtask

  task automatic test_handover();
    req_i = 3'b001;
    set_addr(0, 8'h20);
    step();
    set_addr(0, 8'h21);
    step();
    req_i = 3'b000;
    #1;
    n_cmp++; if (gnt_o !== 3'b000) begin n_bad++; $display("FAIL ho_full_gnt: got %b want %b", gnt_o, 3'b000); end
    set_sel(1, T4);
    rom_rvalid_i = 1'b1;
    rom_rdata_i = 39'h0AAAA;
    #1;
    n_cmp++; if (gnt_o !== 3'b010) begin n_bad++; $display("FAIL ho_gnt_same_cycle: got %b want %b", gnt_o, 3'b010); end
    n_cmp++; if (rvalid_o !== 3'b001) begin n_bad++; $display("FAIL ho_rvalid_first: got %b want %b", rvalid_o, 3'b001); end
    step();
    n_cmp++; if (owner_o !== 2'd1) begin n_bad++; $display("FAIL ho_owner: got %0d want 1", owner_o); end
    rom_rdata_i = 39'h0BBBB;
    #1;
    n_cmp++; if (rvalid_o !== 3'b001) begin n_bad++; $display("FAIL ho_rvalid_second: got %b want %b", rvalid_o, 3'b001); end
    n_cmp++; if (rdata_o !== 39'h0BBBB) begin n_bad++; $display("FAIL ho_rdata_second: got %h want bbbb", rdata_o); end
    step();
    rom_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (alert_o !== 1'b0) begin n_bad++; $display("FAIL ho_alert: got %b want 0", alert_o); end
  endtask

  task automatic test_back_to_back();
    req_i = 3'b010;
    set_addr(1, 8'h30);
    step();
    step();
    n_cmp++; if (gnt_o !== 3'b000) begin n_bad++; $display("FAIL b2b_third_gnt: got %b want %b", gnt_o, 3'b000); end
    n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++; $display("FAIL b2b_third_req: got %b want 0", rom_req_o); end
    rom_rvalid_i = 1'b1;
    #1;
    n_cmp++; if (gnt_o !== 3'b010) begin n_bad++; $display("FAIL b2b_gnt_with_rvalid: got %b want %b", gnt_o, 3'b010); end
    n_cmp++; if (rom_req_o !== 1'b1) begin n_bad++; $display("FAIL b2b_req_with_rvalid: got %b want 1", rom_req_o); end
    n_cmp++; if (rvalid_o !== 3'b010) begin n_bad++; $display("FAIL b2b_rvalid: got %b want %b", rvalid_o, 3'b010); end
    step();
    req_i = 3'b000;
    rom_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (gnt_o !== 3'b000) begin n_bad++; $display("FAIL b2b_count_held: got %b want %b", gnt_o, 3'b000); end
    rom_rvalid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (rvalid_o !== 3'b010) begin n_bad++; $display("FAIL b2b_drain%0d: got %b want %b", i, rvalid_o, 3'b010); end
      step();
    end
    rom_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (alert_o !== 1'b0) begin n_bad++; $display("FAIL b2b_alert: got %b want 0", alert_o); end
  endtask

  task automatic test_regression();
    set_sel(2, T4);
    #1;
    n_cmp++; if (gnt_o !== 3'b100) begin n_bad++; $display("FAIL reg_gnt_to2: got %b want %b", gnt_o, 3'b100); end
    step();
    n_cmp++; if (owner_o !== 2'd2) begin n_bad++; $display("FAIL reg_owner2: got %0d want 2", owner_o); end
    set_sel(2, F4);
    set_sel(1, T4);
    #1;
    n_cmp++; if (gnt_o !== 3'b100) begin n_bad++; $display("FAIL reg_gnt_held: got %b want %b", gnt_o, 3'b100); end
    step();
    n_cmp++; if (alert_o !== 1'b1) begin n_bad++; $display("FAIL reg_alert: got %b want 1", alert_o); end
    n_cmp++; if (owner_o !== 2'd2) begin n_bad++; $display("FAIL reg_owner_kept: got %0d want 2", owner_o); end
    step();
    n_cmp++; if (alert_o !== 1'b1) begin n_bad++; $display("FAIL reg_alert_sticky: got %b want 1", alert_o); end
    do_reset();
    n_cmp++; if (alert_o !== 1'b0) begin n_bad++; $display("FAIL reg_reset_alert: got %b want 0", alert_o); end
  endtask

  task automatic test_invalid_sel();
    set_sel(1, 4'b0000);
    step();
    set_sel(1, F4);
    n_cmp++; if (alert_o !== 1'b1) begin n_bad++; $display("FAIL inv_alert: got %b want 1", alert_o); end
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL inv_owner: got %0d want 0", owner_o); end
    do_reset();
  endtask

  task automatic test_underflow();
    rom_rvalid_i = 1'b1;
    rom_rdata_i = 39'h55;
    #1;
    n_cmp++; if (rvalid_o !== 3'b000) begin n_bad++; $display("FAIL uf_rvalid: got %b want %b", rvalid_o, 3'b000); end
    n_cmp++; if (alert_o !== 1'b0) begin n_bad++; $display("FAIL uf_alert_before: got %b want 0", alert_o); end
    step();
    rom_rvalid_i = 1'b0;
    n_cmp++; if (alert_o !== 1'b1) begin n_bad++; $display("FAIL uf_alert: got %b want 1", alert_o); end
    rst_i = 1'b1;
    #1;
    n_cmp++; if (alert_o !== 1'b0) begin n_bad++; $display("FAIL uf_rst_alert: got %b want 0", alert_o); end
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL uf_rst_owner: got %0d want 0", owner_o); end
    rst_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_handover();
    test_back_to_back();
    test_regression();
    test_invalid_sel();
    test_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
